// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port arbitration bundle: pipeline writeback, LU result handshake,
// and the shared register-file write port plus the stall request back to the pipeline.
// master: pipeline/LU/register-file side; slave: the arbiter.
interface wb_port_arbiter_if;
  // pipeline writeback from the MEM/WB register
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  // long-latency unit result handshake
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  // register-file write port and pipeline stall request
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;

  modport master (
    output wb_we, wb_waddr, wb_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    input  lu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  stall_req
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    output lu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output stall_req
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and queued LU results.
// Latency: one cycle from grant to rf_* outputs; stall_req is registered.
// Backpressure: lu_ready drops when the LU FIFO is full; stall_req on full or starved head.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   bus (slave)    wb_*       pipeline writeback (always wins the port)
//                  lu_*       LU result valid/ready handshake
//                  rf_*       registered register-file write port
//                  stall_req  registered stall request to pipeline control
module wb_port_arbiter #(
  parameter int DEPTH    = 2,  // LU FIFO entries, power of two, >= 2
  parameter int MAX_WAIT = 4   // cycles the FIFO head may starve before stalling
) (
  input logic          clk,
  input logic          rst,
  wb_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] AGE_MAX  = AW'(MAX_WAIT);

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } state_t;

  // LU result FIFO
  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [AW-1:0] age;
  logic [AW-1:0] age_nxt;
  state_t        state;
  state_t        state_nxt;

  logic fifo_empty;
  logic pipe_req;
  logic lu_acc;
  logic lu_nz;
  logic push;
  logic pop;
  logic bypass;

  assign fifo_empty = (count == '0);

  // Writes to r0 are architecturally void, so they never occupy the port.
  assign pipe_req = bus.wb_we & (bus.wb_waddr != 5'd0);

  // Ready looks only at the registered count: a pop this cycle does not make room
  // for a push in the same cycle, which keeps lu_ready off any combinational path.
  assign bus.lu_ready = ~rst & (count != FULL_CNT);

  assign lu_acc = bus.lu_valid & bus.lu_ready;
  // r0 results complete the handshake but are dropped here.
  assign lu_nz  = lu_acc & (bus.lu_waddr != 5'd0);

  // Grant order: pipeline, then FIFO head, then an LU result straight through
  // when nothing is queued ahead of it.
  assign pop    = ~pipe_req & ~fifo_empty;
  assign bypass = ~pipe_req & fifo_empty & lu_nz;
  assign push   = lu_nz & ~bypass;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Head age: any cycle with a non-empty FIFO and no pop means the pipeline took the port.
  always_comb begin
    age_nxt = age;
    if (pop || fifo_empty) begin
      age_nxt = '0;
    end else if (age != AGE_MAX) begin
      age_nxt = age + AW'(1);
    end
  end

  // Once stalling, keep stalling until the FIFO is fully drained so the pipeline
  // does not resume and immediately starve the queue again.
  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL: if (count_nxt == FULL_CNT || age_nxt >= AGE_MAX) state_nxt = STALL;
      STALL:  if (count_nxt == '0) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  // FIFO storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_addr[wr_ptr] <= bus.lu_waddr;
      fifo_data[wr_ptr] <= bus.lu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      age           <= '0;
      state         <= NORMAL;
      bus.stall_req <= 1'b0;
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= 5'd0;
      bus.rf_wdata  <= 32'd0;
    end else begin
      count         <= count_nxt;
      age           <= age_nxt;
      state         <= state_nxt;
      bus.stall_req <= (state_nxt == STALL);

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      if (pipe_req) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= bus.wb_waddr;
        bus.rf_wdata <= bus.wb_wdata;
      end else if (pop) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= fifo_addr[rd_ptr];
        bus.rf_wdata <= fifo_data[rd_ptr];
      end else if (bypass) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= bus.lu_waddr;
        bus.rf_wdata <= bus.lu_wdata;
      end else begin
        // Address/data hold their last values; only the enable drops.
        bus.rf_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, pipeline writes, LU queueing/bypass,
// full and starvation stalls, r0 discard and mid-operation reset.
module tb_wb_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .DEPTH   (2),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs changed after this stay stable
  // until the next edge, outputs read after this reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.wb_we    = we;
    bus.wb_waddr = a;
    bus.wb_wdata = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.lu_valid = v;
    bus.lu_waddr = a;
    bus.lu_wdata = d;
  endtask

  task automatic test_reset();
    logic [37:0] got;
    rst = 1'b1;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    repeat (3) tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b0, 5'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_rf got=%h exp=%h", got, {1'b0, 5'd0, 32'd0});
    end
    checks++;
    if (bus.lu_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_lu_ready_in_rst got=%b exp=0", bus.lu_ready);
    end
    checks++;
    if (bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=0", bus.stall_req);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_lu_ready_release got=%b exp=1", bus.lu_ready);
    end
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b0, 5'd0, 32'd0} || bus.stall_req !== 1'b0 || bus.lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle got rf=%h stall=%b rdy=%b exp rf=%h stall=0 rdy=1",
               got, bus.stall_req, bus.lu_ready, {1'b0, 5'd0, 32'd0});
    end
  endtask

  task automatic test_single_write();
    logic [37:0] got;
    drive_wb(1'b1, 5'd5, 32'hA5);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd5, 32'hA5}) begin
      failures++;
      $display("FAIL single_write got=%h exp=%h", got, {1'b1, 5'd5, 32'hA5});
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b0, 5'd5, 32'hA5}) begin
      failures++;
      $display("FAIL single_write_hold got=%h exp=%h", got, {1'b0, 5'd5, 32'hA5});
    end
  endtask

  task automatic test_collision();
    logic [37:0] got;
    drive_wb(1'b1, 5'd3, 32'h11);
    drive_lu(1'b1, 5'd7, 32'h22);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd3, 32'h11} || bus.lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL collision_t1 got rf=%h rdy=%b exp rf=%h rdy=1",
               got, bus.lu_ready, {1'b1, 5'd3, 32'h11});
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd7, 32'h22}) begin
      failures++;
      $display("FAIL collision_t2 got=%h exp=%h", got, {1'b1, 5'd7, 32'h22});
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      failures++;
      $display("FAIL collision_t3_idle got=%b exp=0", bus.rf_we);
    end
  endtask

  task automatic test_bypass();
    logic [37:0] got;
    drive_lu(1'b1, 5'd4, 32'h44);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd4, 32'h44}) begin
      failures++;
      $display("FAIL bypass got=%h exp=%h", got, {1'b1, 5'd4, 32'h44});
    end
    drive_lu(1'b0, 5'd0, 32'd0);
    tick();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      failures++;
      $display("FAIL bypass_not_queued got=%b exp=0", bus.rf_we);
    end
  endtask

  task automatic test_full_stall();
    logic [37:0] got;
    drive_wb(1'b1, 5'd1, 32'h100);
    drive_lu(1'b1, 5'd8, 32'h88);
    tick();
    checks++;
    if (bus.stall_req !== 1'b0 || bus.lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_one_entry got stall=%b rdy=%b exp stall=0 rdy=1",
               bus.stall_req, bus.lu_ready);
    end
    drive_lu(1'b1, 5'd9, 32'h99);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd1, 32'h100} || bus.stall_req !== 1'b1 || bus.lu_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_reached got rf=%h stall=%b rdy=%b exp rf=%h stall=1 rdy=0",
               got, bus.stall_req, bus.lu_ready, {1'b1, 5'd1, 32'h100});
    end
    // Offered while full: must be refused and never appear on the port.
    drive_lu(1'b1, 5'd10, 32'hAA);
    tick();
    checks++;
    if (bus.stall_req !== 1'b1 || bus.lu_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_hold got stall=%b rdy=%b exp stall=1 rdy=0",
               bus.stall_req, bus.lu_ready);
    end
    drive_lu(1'b0, 5'd0, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd8, 32'h88} || bus.stall_req !== 1'b1 || bus.lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_drain1 got rf=%h stall=%b rdy=%b exp rf=%h stall=1 rdy=1",
               got, bus.stall_req, bus.lu_ready, {1'b1, 5'd8, 32'h88});
    end
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd9, 32'h99} || bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL full_drain2 got rf=%h stall=%b exp rf=%h stall=0",
               got, bus.stall_req, {1'b1, 5'd9, 32'h99});
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      failures++;
      $display("FAIL full_refused_entry got rf_we=%b exp=0", bus.rf_we);
    end
  endtask

  task automatic test_age_stall();
    logic [37:0] got;
    drive_wb(1'b1, 5'd2, 32'h200);
    drive_lu(1'b1, 5'd12, 32'hC);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    // Four cycles where the pipeline keeps the port; stall only at the fourth.
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (bus.stall_req !== (i == 4)) begin
        failures++;
        $display("FAIL age_cycle%0d got stall=%b exp=%b", i, bus.stall_req, (i == 4));
      end
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd12, 32'hC} || bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL age_drain got rf=%h stall=%b exp rf=%h stall=0",
               got, bus.stall_req, {1'b1, 5'd12, 32'hC});
    end
  endtask

  task automatic test_zero_addr();
    drive_wb(1'b1, 5'd0, 32'hDEAD);
    drive_lu(1'b1, 5'd0, 32'hBEEF);
    #1;
    checks++;
    if (bus.lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_handshake got rdy=%b exp=1", bus.lu_ready);
    end
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.rf_we !== 1'b0) begin
      failures++;
      $display("FAIL zero_both got rf_we=%b exp=0", bus.rf_we);
    end
    // Three more r0 results: if any were queued the FIFO would fill.
    repeat (3) tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.rf_we !== 1'b0 || bus.lu_ready !== 1'b1 || bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL zero_lu_not_queued got we=%b rdy=%b stall=%b exp we=0 rdy=1 stall=0",
               bus.rf_we, bus.lu_ready, bus.stall_req);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      failures++;
      $display("FAIL zero_no_late_write got rf_we=%b exp=0", bus.rf_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] got;
    drive_wb(1'b1, 5'd1, 32'h1);
    drive_lu(1'b1, 5'd13, 32'hD);
    tick();
    drive_lu(1'b1, 5'd14, 32'hE);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd13, 32'hD}) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=%h", got, {1'b1, 5'd13, 32'hD});
    end
    drive_wb(1'b1, 5'd15, 32'hF);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd15, 32'hF} || bus.stall_req !== 1'b1) begin
      failures++;
      $display("FAIL b2b_pipe_inflight got rf=%h stall=%b exp rf=%h stall=1",
               got, bus.stall_req, {1'b1, 5'd15, 32'hF});
    end
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    got = {bus.rf_we, bus.rf_waddr, bus.rf_wdata};
    checks++;
    if (got !== {1'b1, 5'd14, 32'hE} || bus.stall_req !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got rf=%h stall=%b exp rf=%h stall=0",
               got, bus.stall_req, {1'b1, 5'd14, 32'hE});
    end
  endtask

  task automatic test_reset_mid();
    drive_wb(1'b1, 5'd1, 32'h1);
    drive_lu(1'b1, 5'd20, 32'h20);
    tick();
    drive_lu(1'b1, 5'd21, 32'h21);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    // Pipeline write in flight when reset hits: it must be lost.
    drive_wb(1'b1, 5'd6, 32'h66);
    rst = 1'b1;
    tick();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.stall_req !== 1'b0 || bus.lu_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_in_reset got we=%b stall=%b rdy=%b exp we=0 stall=0 rdy=0",
               bus.rf_we, bus.stall_req, bus.lu_ready);
    end
    rst = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);
    #1;
    checks++;
    if (bus.lu_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_fifo_cleared got rdy=%b exp=1", bus.lu_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.rf_we !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_no_pending_%0d got rf_we=%b exp=0", i, bus.rf_we);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    test_reset();
    test_single_write();
    test_collision();
    test_bypass();
    test_full_stall();
    test_age_stall();
    test_zero_addr();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
